ripple_count_ctrl: RTL and testbench

Sequencer for the team's T-flip-flop down-counter datapath. It owns a WIDTH-bit down counter. It gates the counter's toggle enable (the T input): T=1 counts, T=0 pauses without losing the count. It adds start/pause/resume/clear commands, terminal-count detection, an optional auto-reload, and a one-cycle done pulse. It sits between a host/control FSM and the counter, and is the single point that decides when the counter advances.

---
 rtl/ripple_count_ctrl_if.sv | 26 ++
 rtl/ripple_count_ctrl.sv | 98 +++++++++
 tb/tb_ripple_count_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ripple_count_ctrl_if.sv
// Command/status bundle between the host sequencer and ripple_count_ctrl.
// The host drives the commands and the start value; the controller returns count and status.
interface ripple_count_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             pause;
   logic             clear;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             t_en;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, pause, clear, auto_reload, load_val,
      input  count, t_en, busy, done, state
   );

   modport slave (
      input  start, pause, clear, auto_reload, load_val,
      output count, t_en, busy, done, state
   );
endinterface

// File: rtl/ripple_count_ctrl.sv
// Sequencer for the T-flip-flop down-counter datapath: gates the toggle enable, handles
// start/pause/resume/clear, terminal-count detection, optional auto-reload and a done pulse.
// All state advances on the falling edge of En.
module ripple_count_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input logic                En,
   input logic                reset,
   ripple_count_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHold = 2'b10,
      StDone = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;

   // State, count and done pulse registers; reset is asynchronous and wins immediately.
   always_ff @(negedge En or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // Next-state and count update; command priority is clear > pause > start.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (bus.clear) begin
         state_d = StIdle;
         count_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!bus.pause && bus.start) begin
                  count_d = bus.load_val;
                  state_d = StRun;
               end
            end
            StRun: begin
               // start is ignored while running; there is no restart.
               if (bus.pause) begin
                  state_d = StHold;
               end else if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  // Terminal count: never wrap below zero.
                  done_d = 1'b1;
                  if (bus.auto_reload) begin
                     count_d = bus.load_val;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
            StHold: begin
               // Resume keeps the held value; no reload.
               if (!bus.pause && bus.start) begin
                  state_d = StRun;
               end
            end
            StDone: begin
               count_d = '0;
               if (!bus.pause && bus.start) begin
                  count_d = bus.load_val;
                  state_d = StRun;
               end
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end
   end

   // Status outputs follow the registered state with no extra delay.
   always_comb begin
      bus.count = count_q;
      bus.done  = done_q;
      bus.state = state_q;
      bus.t_en  = (state_q == StRun);
      bus.busy  = (state_q == StRun) || (state_q == StHold);
   end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Directed bench for ripple_count_ctrl: inputs change and outputs are sampled while En is
// high, half a period away from the active falling edge.
module tb_ripple_count_ctrl;

   logic En;
   logic reset;
   int   checks;
   int   failures;

   ripple_count_ctrl_if #(.WIDTH(4)) bus ();

   ripple_count_ctrl #(.WIDTH(4)) dut (
      .En    (En),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial En = 1'b1;
   always #5 En = ~En;

   // Advance one active (falling) edge and return at the following rising edge.
   task automatic edge_step();
      @(negedge En);
      @(posedge En);
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.pause       = 1'b0;
      bus.clear       = 1'b0;
      bus.auto_reload = 1'b0;
      bus.load_val    = 4'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      edge_step();
      edge_step();
      checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state); end
      checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.t_en !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_flags t_en=%b busy=%b exp=0,0", bus.t_en, bus.busy); end
      reset = 1'b0;
      edge_step();
      // pause alone in IDLE is ignored
      bus.pause = 1'b1;
      edge_step();
      bus.pause = 1'b0;
      checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL idle_pause state=%b exp=00", bus.state); end
   endtask

   task automatic test_basic();
      bus.load_val = 4'd5;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.count !== 4'd5 || bus.state !== 2'b01) begin failures++; $display("FAIL basic_load count=%0d state=%b exp=5,01", bus.count, bus.state); end
      checks++; if (bus.t_en !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL basic_flags t_en=%b busy=%b exp=1,1", bus.t_en, bus.busy); end
      for (int j = 1; j <= 5; j++) begin
         edge_step();
         checks++; if (bus.count !== 4'(5 - j) || bus.done !== 1'b0) begin failures++; $display("FAIL basic_count j=%0d count=%0d done=%b exp=%0d,0", j, bus.count, bus.done, 5 - j); end
      end
      edge_step();
      checks++; if (bus.done !== 1'b1 || bus.state !== 2'b11 || bus.count !== 4'd0) begin failures++; $display("FAIL basic_done done=%b state=%b count=%0d exp=1,11,0", bus.done, bus.state, bus.count); end
      checks++; if (bus.t_en !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_after t_en=%b busy=%b exp=0,0", bus.t_en, bus.busy); end
      edge_step();
      checks++; if (bus.done !== 1'b0 || bus.state !== 2'b11) begin failures++; $display("FAIL basic_pulse done=%b state=%b exp=0,11", bus.done, bus.state); end
   endtask

   task automatic test_pause_resume();
      int run_edges;
      bus.load_val = 4'd9;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      run_edges = 0;
      for (int j = 1; j <= 3; j++) begin
         edge_step();
         run_edges++;
      end
      checks++; if (bus.count !== 4'd6) begin failures++; $display("FAIL pause_pre count=%0d exp=6", bus.count); end
      bus.pause = 1'b1;
      for (int j = 0; j < 4; j++) begin
         edge_step();
         checks++; if (bus.count !== 4'd6 || bus.state !== 2'b10 || bus.done !== 1'b0 || bus.t_en !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL pause_hold j=%0d count=%0d state=%b done=%b t_en=%b busy=%b exp=6,10,0,0,1", j, bus.count, bus.state, bus.done, bus.t_en, bus.busy); end
      end
      bus.pause = 1'b0;
      bus.start = 1'b1;
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.count !== 4'd6 || bus.state !== 2'b01) begin failures++; $display("FAIL pause_resume count=%0d state=%b exp=6,01", bus.count, bus.state); end
      for (int j = 1; j <= 6; j++) begin
         edge_step();
         run_edges++;
         checks++; if (bus.count !== 4'(6 - j) || bus.done !== 1'b0) begin failures++; $display("FAIL pause_count j=%0d count=%0d done=%b exp=%0d,0", j, bus.count, bus.done, 6 - j); end
      end
      edge_step();
      run_edges++;
      checks++; if (bus.done !== 1'b1 || bus.state !== 2'b11 || run_edges != 10) begin failures++; $display("FAIL pause_done done=%b state=%b run_edges=%0d exp=1,11,10", bus.done, bus.state, run_edges); end
   endtask

   task automatic test_reload();
      logic [3:0] exp_cnt [6];
      logic       exp_done [6];
      exp_cnt  = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
      exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      bus.auto_reload = 1'b1;
      bus.load_val    = 4'd2;
      bus.start       = 1'b1;
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.count !== 4'd2) begin failures++; $display("FAIL reload_load count=%0d exp=2", bus.count); end
      for (int j = 0; j < 6; j++) begin
         edge_step();
         checks++; if (bus.count !== exp_cnt[j] || bus.done !== exp_done[j] || bus.state !== 2'b01) begin failures++; $display("FAIL reload_seq j=%0d count=%0d done=%b state=%b exp=%0d,%b,01", j, bus.count, bus.done, bus.state, exp_cnt[j], exp_done[j]); end
      end
      bus.auto_reload = 1'b0;
      bus.clear       = 1'b1;
      edge_step();
      bus.clear = 1'b0;
      checks++; if (bus.state !== 2'b00 || bus.count !== 4'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL reload_clear state=%b count=%0d done=%b exp=00,0,0", bus.state, bus.count, bus.done); end
   endtask

   task automatic test_async_reset();
      bus.load_val = 4'd5;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      edge_step();
      edge_step();
      checks++; if (bus.count !== 4'd3) begin failures++; $display("FAIL areset_pre count=%0d exp=3", bus.count); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.count !== 4'd0 || bus.state !== 2'b00 || bus.done !== 1'b0) begin failures++; $display("FAIL areset_now count=%0d state=%b done=%b exp=0,00,0", bus.count, bus.state, bus.done); end
      reset = 1'b0;
      @(posedge En);
   endtask

   task automatic test_collision();
      bus.load_val = 4'd2;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      edge_step();
      edge_step();
      bus.pause = 1'b1;
      bus.start = 1'b1;
      bus.clear = 1'b1;
      edge_step();
      idle_inputs();
      checks++; if (bus.state !== 2'b00 || bus.count !== 4'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL coll_all state=%b count=%0d done=%b exp=00,0,0", bus.state, bus.count, bus.done); end
      bus.load_val = 4'd2;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      edge_step();
      edge_step();
      bus.pause = 1'b1;
      bus.start = 1'b1;
      edge_step();
      bus.pause = 1'b0;
      checks++; if (bus.state !== 2'b10 || bus.count !== 4'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL coll_pause state=%b count=%0d done=%b exp=10,0,0", bus.state, bus.count, bus.done); end
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.state !== 2'b01 || bus.done !== 1'b0) begin failures++; $display("FAIL coll_resume state=%b done=%b exp=01,0", bus.state, bus.done); end
      edge_step();
      checks++; if (bus.done !== 1'b1 || bus.state !== 2'b11) begin failures++; $display("FAIL coll_done done=%b state=%b exp=1,11", bus.done, bus.state); end
   endtask

   task automatic test_zero_and_wrap();
      bus.load_val = 4'd0;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.state !== 2'b01 || bus.count !== 4'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL zero_load state=%b count=%0d done=%b exp=01,0,0", bus.state, bus.count, bus.done); end
      edge_step();
      checks++; if (bus.done !== 1'b1 || bus.state !== 2'b11) begin failures++; $display("FAIL zero_done done=%b state=%b exp=1,11", bus.done, bus.state); end
      bus.load_val = 4'd15;
      bus.start    = 1'b1;
      edge_step();
      bus.start = 1'b0;
      checks++; if (bus.count !== 4'd15) begin failures++; $display("FAIL wrap_load count=%0d exp=15", bus.count); end
      for (int j = 1; j <= 15; j++) begin
         // start mid-run must not restart the count
         bus.start = (j == 7);
         edge_step();
         checks++; if (bus.count !== 4'(15 - j)) begin failures++; $display("FAIL wrap_count j=%0d count=%0d exp=%0d", j, bus.count, 15 - j); end
      end
      bus.start = 1'b0;
      edge_step();
      checks++; if (bus.count !== 4'd0 || bus.done !== 1'b1 || bus.state !== 2'b11) begin failures++; $display("FAIL wrap_term count=%0d done=%b state=%b exp=0,1,11", bus.count, bus.done, bus.state); end
      edge_step();
      checks++; if (bus.count !== 4'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL wrap_after count=%0d done=%b exp=0,0", bus.count, bus.done); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      test_reset();
      test_basic();
      test_pause_resume();
      test_reload();
      test_async_reset();
      test_collision();
      test_zero_and_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time bound in case a wait never returns.
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
